// File: rtl/power_domain_sequencer_pkg.sv
// Shared types for the power-domain sequencer: FSM state encoding and the per-state output decode.
// The decode table is the single place that defines what each state drives at the domain boundary.
package pds_pkg;

    typedef enum logic [3:0] {
        ACTIVE,
        ISOLATE,
        SAVE_ST,
        CLK_STOP,
        PWR_DOWN,
        SLEEP,
        PWR_UP,
        DOM_RESET,
        RESTORE_ST,
        DEISO,
        FAULT
    } pds_state_e;

    typedef struct packed {
        logic iso;
        logic ls_enb;
        logic clk_en;
        logic save;
        logic restore;
        logic dom_rst;
        logic pwr_en;
        logic domain_on;
        logic busy;
    } pds_out_t;

    localparam pds_out_t PDS_OUT_ACTIVE   = 9'b111_000_110;
    localparam pds_out_t PDS_OUT_ISOLATE  = 9'b001_000_101;
    localparam pds_out_t PDS_OUT_SAVE     = 9'b001_100_101;
    localparam pds_out_t PDS_OUT_CLK_STOP = 9'b000_000_101;
    localparam pds_out_t PDS_OUT_PWR_DOWN = 9'b000_000_001;
    localparam pds_out_t PDS_OUT_SLEEP    = 9'b000_000_000;
    localparam pds_out_t PDS_OUT_PWR_UP   = 9'b000_001_101;
    localparam pds_out_t PDS_OUT_DOM_RST  = 9'b001_001_101;
    localparam pds_out_t PDS_OUT_RESTORE  = 9'b001_010_101;
    localparam pds_out_t PDS_OUT_DEISO    = 9'b001_000_101;
    localparam pds_out_t PDS_OUT_FAULT    = 9'b000_001_100;

    localparam pds_out_t PDS_OUT_RST = PDS_OUT_ACTIVE;
    localparam logic     PDS_ERR_RST = 1'b0;

    // Isolation stays clamped until ACTIVE is entered, so only ACTIVE drives iso/ls_enb high.
    function automatic pds_out_t pds_decode(input pds_state_e s);
        pds_out_t o;
        case (s)
            ACTIVE:     o = PDS_OUT_ACTIVE;
            ISOLATE:    o = PDS_OUT_ISOLATE;
            SAVE_ST:    o = PDS_OUT_SAVE;
            CLK_STOP:   o = PDS_OUT_CLK_STOP;
            PWR_DOWN:   o = PDS_OUT_PWR_DOWN;
            SLEEP:      o = PDS_OUT_SLEEP;
            PWR_UP:     o = PDS_OUT_PWR_UP;
            DOM_RESET:  o = PDS_OUT_DOM_RST;
            RESTORE_ST: o = PDS_OUT_RESTORE;
            DEISO:      o = PDS_OUT_DEISO;
            FAULT:      o = PDS_OUT_FAULT;
            default:    o = PDS_OUT_RST;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/power_domain_sequencer_if.sv
// Boundary bundle between always-on power management and the switchable domain.
// The sequencer takes the slave side; the requester/power switch model takes the master side.
interface power_domain_sequencer_if;
    logic sleep_req;
    logic wake_req;
    logic pwr_ack;
    logic iso;
    logic ls_enb;
    logic clk_en;
    logic save;
    logic restore;
    logic dom_rst;
    logic pwr_en;
    logic domain_on;
    logic busy;
    logic err;

    modport master (
        output sleep_req, wake_req, pwr_ack,
        input  iso, ls_enb, clk_en, save, restore, dom_rst, pwr_en, domain_on, busy, err
    );

    modport slave (
        input  sleep_req, wake_req, pwr_ack,
        output iso, ls_enb, clk_en, save, restore, dom_rst, pwr_en, domain_on, busy, err
    );
endinterface

// File: rtl/power_domain_sequencer_timer.sv
// Down-counter shared by the settle and power-switch timeout states.
// Loads on request, then counts down and parks at zero; done is high while the count is zero.
module pds_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/power_domain_sequencer.sv
// Power-down / power-up sequencer for one switchable domain; all boundary controls are registered state decodes.
// Build option: define PDS_ACK_SYNC_EN to pass PWR_ACK through a 2-flop synchronizer (reset to 1) before use.
module power_domain_sequencer
    import pds_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int PSW_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input logic                     clk,
    input logic                     rst,
    power_domain_sequencer_if.slave pds
);

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(PSW_TIMEOUT - 1);

    pds_state_e       state_q, state_d;
    pds_out_t         out_q;
    logic             err_q, err_d;
    logic             ack;
    logic             tmr_load;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_ld_val;
    logic [CNT_W-1:0] tmr_val;
    logic             unused_tmr_val;

`ifdef PDS_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_q <= 2'b11;
        end else begin
            ack_sync_q <= {ack_sync_q[0], pds.pwr_ack};
        end
    end

    assign ack = ack_sync_q[1];
`else
    assign ack = pds.pwr_ack;
`endif

    // An ack match in the cycle the count hits zero wins over the timeout.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ACTIVE:     if (pds.sleep_req) state_d = ISOLATE;
            ISOLATE:    if (tmr_done) state_d = SAVE_ST;
            SAVE_ST:    state_d = CLK_STOP;
            CLK_STOP:   state_d = PWR_DOWN;
            PWR_DOWN: begin
                if (!ack) begin
                    state_d = SLEEP;
                end else if (tmr_done) begin
                    state_d = SLEEP;
                    err_d   = 1'b1;
                end
            end
            SLEEP:      if (pds.wake_req) state_d = PWR_UP;
            PWR_UP: begin
                if (ack) begin
                    state_d = DOM_RESET;
                end else if (tmr_done) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end
            end
            DOM_RESET:  if (tmr_done) state_d = RESTORE_ST;
            RESTORE_ST: state_d = DEISO;
            DEISO:      if (tmr_done) state_d = ACTIVE;
            FAULT:      state_d = FAULT;
            default:    state_d = ACTIVE;
        endcase
    end

    assign tmr_load   = (state_d != state_q);
    assign tmr_ld_val = (state_d == PWR_DOWN || state_d == PWR_UP) ? TIMEOUT_LD : SETTLE_LD;

    pds_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_ld_val),
        .cnt_o      (tmr_val),
        .done_o     (tmr_done)
    );

    assign unused_tmr_val = ^tmr_val;

    // Outputs decode the next state so they change on the edge that enters each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACTIVE;
            out_q   <= PDS_OUT_RST;
            err_q   <= PDS_ERR_RST;
        end else begin
            state_q <= state_d;
            out_q   <= pds_decode(state_d);
            err_q   <= err_d;
        end
    end

    assign pds.iso       = out_q.iso;
    assign pds.ls_enb    = out_q.ls_enb;
    assign pds.clk_en    = out_q.clk_en;
    assign pds.save      = out_q.save;
    assign pds.restore   = out_q.restore;
    assign pds.dom_rst   = out_q.dom_rst;
    assign pds.pwr_en    = out_q.pwr_en;
    assign pds.domain_on = out_q.domain_on;
    assign pds.busy      = out_q.busy;
    assign pds.err       = err_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Cycle-accurate scoreboard bench for power_domain_sequencer with default parameters.
// Each driven cycle pushes the boundary vector expected after the next edge; it is popped and compared #1 after that edge.
module tb_power_domain_sequencer;

    // Vector order: iso, ls_enb, clk_en, save, restore, dom_rst, pwr_en, domain_on, busy, err
    localparam logic [9:0] E_ACT   = 10'b111_000_110_0;
    localparam logic [9:0] E_ISO   = 10'b001_000_101_0;
    localparam logic [9:0] E_SAV   = 10'b001_100_101_0;
    localparam logic [9:0] E_CST   = 10'b000_000_101_0;
    localparam logic [9:0] E_PDN   = 10'b000_000_001_0;
    localparam logic [9:0] E_SLP   = 10'b000_000_000_0;
    localparam logic [9:0] E_SLPE  = 10'b000_000_000_1;
    localparam logic [9:0] E_PUP   = 10'b000_001_101_0;
    localparam logic [9:0] E_DRS   = 10'b001_001_101_0;
    localparam logic [9:0] E_RES   = 10'b001_010_101_0;
    localparam logic [9:0] E_DEI   = 10'b001_000_101_0;
    localparam logic [9:0] E_FLT   = 10'b000_001_100_1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   totalChecks = 0;
    int   badChecks   = 0;
    logic [9:0] expQ[$];

    power_domain_sequencer_if pdsIf ();

    power_domain_sequencer #(
        .SETTLE_CYC  (4),
        .PSW_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pds (pdsIf)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {pdsIf.iso, pdsIf.ls_enb, pdsIf.clk_en, pdsIf.save, pdsIf.restore,
                pdsIf.dom_rst, pdsIf.pwr_en, pdsIf.domain_on, pdsIf.busy, pdsIf.err};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got %b want %b (iso ls clk sav res drst pwr on busy err)", tag, got, want);
        end
    endtask

    task automatic popAndCheck(input string tag);
        logic [9:0] want;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_noexp"}, observed(), 10'bx);
        end else begin
            want = expQ.pop_front();
            checkOutput(tag, observed(), want);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic sleepReq, input logic wakeReq,
                                 input logic pwrAck, input logic [9:0] expNext);
        pdsIf.sleep_req = sleepReq;
        pdsIf.wake_req  = wakeReq;
        pdsIf.pwr_ack   = pwrAck;
        expQ.push_back(expNext);
        @(posedge clk);
        #1;
        popAndCheck(tag);
    endtask

    task automatic stepN(input string tag, input int n, input logic sleepReq, input logic wakeReq,
                         input logic pwrAck, input logic [9:0] expNext);
        for (int i = 0; i < n; i++) begin
            applyStimulus($sformatf("%s%0d", tag, i), sleepReq, wakeReq, pwrAck, expNext);
        end
    endtask

    // Reset is checked 1 time unit after assertion to exercise the asynchronous path.
    task automatic resetDut(input string tag, input logic pwrAck);
        pdsIf.sleep_req = 1'b0;
        pdsIf.wake_req  = 1'b0;
        pdsIf.pwr_ack   = pwrAck;
        rst = 1'b1;
        expQ.push_back(E_ACT);
        #1;
        popAndCheck(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        pdsIf.sleep_req = 1'b0;
        pdsIf.wake_req  = 1'b0;
        pdsIf.pwr_ack   = 1'b1;
        #2;
        resetDut("reset", 1'b1);

        // Idle in ACTIVE; wake requests there must be ignored.
        stepN("idle", 10, 1'b0, 1'b0, 1'b1, E_ACT);
        stepN("idle_wake", 10, 1'b0, 1'b1, 1'b1, E_ACT);

        // Power-down with the switch acknowledging 3 cycles after PWR_EN drops.
        applyStimulus("pd_iso_first", 1'b1, 1'b0, 1'b1, E_ISO);
        stepN("pd_iso", 3, 1'b0, 1'b0, 1'b1, E_ISO);
        applyStimulus("pd_save", 1'b0, 1'b0, 1'b1, E_SAV);
        applyStimulus("pd_clkstop", 1'b0, 1'b0, 1'b1, E_CST);
        applyStimulus("pd_pwren", 1'b0, 1'b0, 1'b1, E_PDN);
        stepN("pd_wait", 3, 1'b0, 1'b0, 1'b1, E_PDN);
        applyStimulus("pd_sleep", 1'b0, 1'b0, 1'b0, E_SLP);
        stepN("sleep_ign", 3, 1'b1, 1'b0, 1'b0, E_SLP);

        // Wake with ack 2 cycles after PWR_EN; sleep request raised during DEISO is honoured after ACTIVE.
        applyStimulus("wu_pwrup", 1'b0, 1'b1, 1'b0, E_PUP);
        stepN("wu_wait", 2, 1'b0, 1'b0, 1'b0, E_PUP);
        stepN("wu_domrst", 4, 1'b0, 1'b0, 1'b1, E_DRS);
        applyStimulus("wu_restore", 1'b0, 1'b0, 1'b1, E_RES);
        stepN("wu_deiso", 4, 1'b1, 1'b0, 1'b1, E_DEI);
        applyStimulus("wu_active", 1'b1, 1'b0, 1'b1, E_ACT);

        // Power-down with PWR_ACK stuck high: timeout after 16 cycles, SLEEP still entered.
        applyStimulus("stk_iso_first", 1'b1, 1'b0, 1'b1, E_ISO);
        stepN("stk_iso", 3, 1'b0, 1'b0, 1'b1, E_ISO);
        applyStimulus("stk_save", 1'b0, 1'b0, 1'b1, E_SAV);
        applyStimulus("stk_clkstop", 1'b0, 1'b0, 1'b1, E_CST);
        stepN("stk_pdn", 16, 1'b0, 1'b0, 1'b1, E_PDN);
        applyStimulus("stk_sleep_err", 1'b0, 1'b0, 1'b1, E_SLPE);
        stepN("stk_err_sticky", 2, 1'b0, 1'b0, 1'b1, E_SLPE);

        // Reset from SLEEP, then a clean power-down with immediate ack.
        resetDut("reset_from_sleep", 1'b1);
        applyStimulus("pd2_iso_first", 1'b1, 1'b0, 1'b1, E_ISO);
        stepN("pd2_iso", 3, 1'b0, 1'b0, 1'b1, E_ISO);
        applyStimulus("pd2_save", 1'b0, 1'b0, 1'b1, E_SAV);
        applyStimulus("pd2_clkstop", 1'b0, 1'b0, 1'b1, E_CST);
        applyStimulus("pd2_pwren", 1'b0, 1'b0, 1'b0, E_PDN);
        applyStimulus("pd2_sleep", 1'b0, 1'b0, 1'b0, E_SLP);

        // Wake with PWR_ACK stuck low: FAULT after 16 cycles, requests ignored there.
        applyStimulus("wt_pwrup", 1'b0, 1'b1, 1'b0, E_PUP);
        stepN("wt_wait", 15, 1'b0, 1'b1, 1'b0, E_PUP);
        applyStimulus("wt_fault", 1'b0, 1'b0, 1'b0, E_FLT);
        stepN("fault_hold", 4, 1'b1, 1'b1, 1'b1, E_FLT);
        resetDut("reset_from_fault", 1'b1);
        applyStimulus("post_fault_idle", 1'b0, 1'b0, 1'b1, E_ACT);

        // Both requests high in ACTIVE start a power-down; reset lands in PWR_DOWN.
        applyStimulus("both_iso", 1'b1, 1'b1, 1'b1, E_ISO);
        stepN("both_iso_hold", 3, 1'b0, 1'b0, 1'b1, E_ISO);
        applyStimulus("both_save", 1'b0, 1'b0, 1'b1, E_SAV);
        applyStimulus("both_clkstop", 1'b0, 1'b0, 1'b1, E_CST);
        stepN("both_pdn", 3, 1'b0, 1'b0, 1'b1, E_PDN);
        resetDut("reset_in_pwrdown", 1'b1);
        stepN("final_idle", 3, 1'b0, 1'b0, 1'b1, E_ACT);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/power_domain_sequencer.md
Name: power_domain_sequencer

Overview:
- Sequences power-down and power-up of one switchable domain built from the team's cell library.
- Drives the isolation cells (ISOLAND*, ISO input: 1=pass, 0=clamp output to 0), the enable level shifters (LSDNENX1, ENB input: 1=pass, 0=force output 1), retention save/restore, clock gating, domain reset and the power-switch enable.
- Sits between the always-on power-management logic and the domain boundary.

Parameters:
- SETTLE_CYC, 4, cycles held in each settle state (ISOLATE, DOM_RESET, DEISO); legal range 1..2^CNT_W-1.
- PSW_TIMEOUT, 16, max cycles to wait for PWR_ACK before a timeout is declared; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the shared down-counter.

Ports:
- CLK  in  1  clock for all state.
- RST  in  1  asynchronous, active-high reset.
- SLEEP_REQ  in  1  level request to power down; sampled only in ACTIVE.
- WAKE_REQ  in  1  level request to power up; sampled only in SLEEP.
- PWR_ACK  in  1  power-switch status: 1 = domain powered.
- ISO  out  1  to ISOLAND ISO pins; 0 = clamp.
- LS_ENB  out  1  to LSDNENX1 ENB pins; 0 = force 1.
- CLK_EN  out  1  domain clock-gate enable.
- SAVE  out  1  one-cycle retention save pulse.
- RESTORE  out  1  one-cycle retention restore pulse.
- DOM_RST  out  1  domain reset, active-high.
- PWR_EN  out  1  power-switch enable.
- DOMAIN_ON  out  1  1 only in ACTIVE.
- BUSY  out  1  1 in any state other than ACTIVE, SLEEP or FAULT.
- ERR  out  1  sticky timeout flag; cleared only by RST.

Behaviour:
- All outputs are registered Moore decodes of state. Each output changes on the clock edge that enters the state.
- Reset state is ACTIVE. Reset values: ISO=1, LS_ENB=1, CLK_EN=1, SAVE=0, RESTORE=0, DOM_RST=0, PWR_EN=1, DOMAIN_ON=1, BUSY=0, ERR=0.
- RST asserted mid-sequence returns to ACTIVE with the reset values immediately (asynchronous).
- Power-down path:
  - ACTIVE: if SLEEP_REQ=1 -> ISOLATE. Entering ISOLATE sets ISO=0, LS_ENB=0, DOMAIN_ON=0, BUSY=1. WAKE_REQ is ignored in ACTIVE.
  - ISOLATE: held exactly SETTLE_CYC cycles -> SAVE_ST.
  - SAVE_ST: 1 cycle with SAVE=1 -> CLK_STOP.
  - CLK_STOP: 1 cycle with CLK_EN=0 -> PWR_DOWN.
  - PWR_DOWN: PWR_EN=0. Wait for PWR_ACK=0, then -> SLEEP. If PSW_TIMEOUT cycles elapse first, set ERR=1 and still -> SLEEP.
- SLEEP:
  - ISO=0, LS_ENB=0, CLK_EN=0, PWR_EN=0, BUSY=0.
  - WAKE_REQ=1 -> PWR_UP. SLEEP_REQ is ignored.
- Power-up path:
  - PWR_UP: PWR_EN=1, DOM_RST=1. Wait for PWR_ACK=1, then -> DOM_RESET. If PSW_TIMEOUT cycles elapse first, set ERR=1 -> FAULT.
  - DOM_RESET: CLK_EN=1, DOM_RST=1, held SETTLE_CYC cycles -> RESTORE_ST.
  - RESTORE_ST: DOM_RST=0, RESTORE=1 for 1 cycle -> DEISO.
  - DEISO: held SETTLE_CYC cycles with isolation still on -> ACTIVE. ISO and LS_ENB go to 1 on entry to ACTIVE.
- FAULT:
  - PWR_EN=1, ISO=0, LS_ENB=0, CLK_EN=0, DOM_RST=1, BUSY=0, ERR=1.
  - Exit only via RST.
- Requests during transition states are ignored, not queued. A level request still high on arrival at ACTIVE or SLEEP is acted on in the next cycle.
- Timeout counting: the count is loaded on state entry and decremented each cycle. A PWR_ACK match in the same cycle the count reaches 0 counts as success.
- Output invariants:
  - ISO=1 implies PWR_EN=1, CLK_EN=1 and DOM_RST=0.
  - SAVE and RESTORE are never both 1.

Optional Feature:
- PDS_ACK_SYNC_EN defined: PWR_ACK passes through a 2-flop synchronizer (reset to 1) before use, adding 2 cycles of ack latency. Timeout counting is unchanged.
- Not defined: PWR_ACK is used directly and must be synchronous to CLK.

Decomposition:
- Package pds_pkg holds:
  - the state enum (ACTIVE, ISOLATE, SAVE_ST, CLK_STOP, PWR_DOWN, SLEEP, PWR_UP, DOM_RESET, RESTORE_ST, DEISO, FAULT);
  - the reset values of the output vector as constants.
- One sub-module, pds_timer: a CNT_W down-counter with load, value and done flag. It is shared by the settle and timeout states.

Test Plan:
- Reset then idle 20 cycles -> ISO=1, LS_ENB=1, PWR_EN=1, CLK_EN=1, DOMAIN_ON=1, BUSY=0, ERR=0 throughout.
- SLEEP_REQ pulse at cycle 0, PWR_ACK falls 3 cycles after PWR_EN=0 (defaults):
  - ISO=0 from cycle 1, for 4 cycles;
  - SAVE=1 at cycle 5;
  - CLK_EN=0 at cycle 6;
  - PWR_EN=0 at cycle 7;
  - SLEEP reached at cycle 11, ERR=0.
- From SLEEP, WAKE_REQ=1 and PWR_ACK rises 2 cycles later:
  - DOM_RST=1 until RESTORE;
  - RESTORE exactly 1 cycle;
  - ISO=1 only after the 4 DEISO cycles;
  - DOMAIN_ON=1 at the end.
- PWR_ACK stuck at 0 during wake -> after 16 cycles ERR=1, state FAULT, ISO=0. A later WAKE_REQ or SLEEP_REQ has no effect; RST restores the reset values.
- PWR_ACK stuck at 1 during sleep -> ERR=1 after 16 cycles and SLEEP is still entered.
- SLEEP_REQ and WAKE_REQ both high in ACTIVE -> power-down starts. RST asserted in PWR_DOWN -> next sample shows ACTIVE reset values.
